// File: rtl/ysyx_050518_mem_arbiter_pkg.sv
// rtl/ysyx_050518_mem_arbiter_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package ysyx_050518_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // The owner encoding doubles as the bit index into the arbiter req/gnt vectors.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [2:0] IFU_SIZE = 3'b010;

endpackage

// File: rtl/ysyx_050518_rr_arb2.sv
// rtl/ysyx_050518_rr_arb2.sv - combinational two-way round-robin grant (bit 0 = IFU, bit 1 = LSU)
module ysyx_050518_rr_arb2
  import ysyx_050518_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_050518_mem_arbiter.sv
// rtl/ysyx_050518_mem_arbiter.sv - single-outstanding IFU/LSU arbiter for the shared memory bus
// Optional response timeout with bus_err: define YSYX_050518_MEM_ARB_TIMEOUT_EN.
module ysyx_050518_mem_arbiter
  import ysyx_050518_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [31:0]       ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_write,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_size,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              bus_valid,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [2:0]        bus_size,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [1:0]        gnt;
  logic              capture;
  logic              timeout;
  logic              timeout_hit;

  ysyx_050518_rr_arb2 u_rr_arb2 (
    .req        ({lsu_req, ifu_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

`ifdef YSYX_050518_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;

  // Restarts on every state change so ISSUE and WAIT each get the full budget.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q) || !(state_q inside {ISSUE, WAIT})) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
    err_q <= !rst && timeout_hit;
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d   = state_q;
    ifu_ready = 1'b0;
    lsu_ready = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && (gnt != 2'b00)) begin
          ifu_ready = gnt[OWN_IFU];
          lsu_ready = gnt[OWN_LSU];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_ready && bus_rvalid) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (bus_ready) begin
          state_d = WAIT;
        end else if (timeout) begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  assign timeout_hit = (state_q inside {ISSUE, WAIT}) && (state_d == RESP) && !capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_LSU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      size_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (ifu_ready || lsu_ready) begin
        owner_q      <= lsu_ready ? OWN_LSU : OWN_IFU;
        last_grant_q <= lsu_ready ? OWN_LSU : OWN_IFU;
        addr_q       <= lsu_ready ? lsu_addr : ifu_addr;
        write_q      <= lsu_ready && lsu_write;
        wdata_q      <= lsu_ready ? lsu_wdata : '0;
        size_q       <= lsu_ready ? lsu_size : IFU_SIZE;
      end
      // Store acks and timeouts both return zero data.
      if ((state_d == RESP) && (state_q != RESP)) begin
        rdata_q <= (capture && !write_q) ? bus_rdata : '0;
      end
    end
  end

  assign bus_valid  = (state_q == ISSUE);
  assign bus_write  = write_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_size   = size_q;
  assign ifu_rvalid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_rvalid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata  = ifu_rvalid ? rdata_q[31:0] : 32'd0;
  assign lsu_rdata  = lsu_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_050518_mem_arbiter.sv
// tb/tb_ysyx_050518_mem_arbiter.sv - directed and randomized bench for ysyx_050518_mem_arbiter
module tb_ysyx_050518_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic [63:0] ifu_addr;
  logic [31:0] ifu_rdata;
  logic        lsu_req, lsu_write, lsu_ready, lsu_rvalid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_size;
  logic        bus_valid, bus_write, bus_ready, bus_rvalid, bus_err;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_size;

  always #5 clk = ~clk;

  ysyx_050518_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_write(lsu_write), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_size(lsu_size), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, round-robin on contention.
  bit          m_busy, m_offer, m_wait, m_resp, m_last, m_own, m_write;
  logic [63:0] m_addr, m_wdata, m_cap;
  logic [2:0]  m_size;
  bit          g_ifu, g_lsu;
  int          rv_cyc, rv_left;

  task automatic model_reset();
    m_busy = 0; m_offer = 0; m_wait = 0; m_resp = 0;
    m_last = 0; m_own = 1;
  endtask

  // Called at a falling edge with this cycle's inputs applied; returns at the next falling edge.
  task automatic step();
    bit ei, el;
    #1;
    ei = 0; el = 0;
    if (!m_busy) begin
      if (ifu_req && lsu_req) begin
        el = (m_last == 0);
        ei = !el;
      end else begin
        ei = ifu_req;
        el = lsu_req;
      end
    end
    check("ifu_ready", ifu_ready, ei);
    check("lsu_ready", lsu_ready, el);
    check("bus_valid", bus_valid, m_offer);
    check("ifu_rvalid", ifu_rvalid, m_resp && !m_own);
    check("lsu_rvalid", lsu_rvalid, m_resp && m_own);
    check("bus_err", bus_err, 0);
    if (m_offer) begin
      check("bus_addr", bus_addr, m_addr);
      check("bus_write", bus_write, m_write);
      check("bus_size", bus_size, m_size);
      if (m_write) check("bus_wdata", bus_wdata, m_wdata);
    end
    if (m_resp && !m_own) check("ifu_rdata", ifu_rdata, m_cap[31:0]);
    if (m_resp && m_own) check("lsu_rdata", lsu_rdata, m_write ? 64'd0 : m_cap);
    if ((ifu_rvalid || lsu_rvalid) && rv_cyc < 0) rv_cyc = cyc;
    g_ifu = ei;
    g_lsu = el;
    if (m_resp) begin
      m_resp = 0;
      m_busy = 0;
    end else if (m_offer && bus_ready) begin
      m_offer = 0;
      if (bus_rvalid) begin
        m_resp = 1;
        m_cap  = bus_rdata;
      end else begin
        m_wait = 1;
      end
    end else if (m_wait && bus_rvalid) begin
      m_wait = 0;
      m_resp = 1;
      m_cap  = bus_rdata;
    end
    if (ei || el) begin
      m_busy  = 1;
      m_offer = 1;
      m_own   = el;
      m_last  = el;
      m_addr  = el ? lsu_addr : ifu_addr;
      m_write = el && lsu_write;
      m_wdata = lsu_wdata;
      m_size  = el ? lsu_size : 3'b010;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; ifu_req = 0; lsu_req = 0; bus_ready = 0; bus_rvalid = 0;
    @(negedge clk);
    check("rst_ctrl", {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, bus_valid, bus_write, bus_err}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_size", bus_size, 0);
    check("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int t0, ifu_g, lsu_g;
    bit seen;
    rst = 1; ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_write = 0;
    lsu_addr = 0; lsu_wdata = 0; lsu_size = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0; rv_left = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // LSU-only load with a two-cycle response gap.
    t0 = cyc; rv_cyc = -1;
    lsu_req = 1; lsu_write = 0; lsu_addr = 64'ha000_0048; lsu_size = 3'b010;
    step(); lsu_req = 0;
    bus_ready = 1; step(); bus_ready = 0;
    step();
    bus_rvalid = 1; bus_rdata = 64'h1234_5678; step(); bus_rvalid = 0;
    step();
    check("load_latency", rv_cyc - t0, 4);

    // Contention straight after reset, bus answering in the accept cycle.
    do_reset();
    t0 = cyc; rv_cyc = -1; ifu_g = -1; lsu_g = -1;
    ifu_req = 1; ifu_addr = 64'h8000_0000;
    lsu_req = 1; lsu_addr = 64'h8000_1000; lsu_write = 0; lsu_size = 3'b011;
    for (int i = 0; i < 12; i++) begin
      bus_ready = m_offer; bus_rvalid = m_offer; bus_rdata = {$urandom, $urandom};
      step();
      if (g_lsu) begin lsu_g = cyc - 1 - t0; lsu_req = 0; end
      if (g_ifu) begin ifu_g = cyc - 1 - t0; ifu_req = 0; end
    end
    bus_ready = 0; bus_rvalid = 0;
    check("rr_lsu_first", lsu_g, 0);
    check("rr_ifu_after_resp", ifu_g, 3);
    check("same_cycle_latency", rv_cyc - t0, 2);

    // Store: zero data on the ack.
    lsu_req = 1; lsu_write = 1; lsu_wdata = 64'hdead_beef; lsu_size = 3'b000; lsu_addr = 64'h100;
    step(); lsu_req = 0; lsu_write = 0;
    #1;
    check("st_bus_write", bus_write, 1);
    check("st_bus_wdata", bus_wdata, 64'hdead_beef);
    check("st_bus_size", bus_size, 0);
    @(negedge clk);
    bus_ready = 1; bus_rvalid = 1; bus_rdata = 64'hffff_ffff_ffff_ffff; step();
    bus_ready = 0; bus_rvalid = 0;
    step();

    // Reset while waiting for the response; the late response must vanish.
    rv_cyc = -1;
    lsu_req = 1; lsu_addr = 64'h200; lsu_size = 3'b011;
    step(); lsu_req = 0;
    bus_ready = 1; step(); bus_ready = 0;
    step();
    do_reset();
    bus_rvalid = 1; bus_rdata = 64'h55; step(); bus_rvalid = 0;
    step(); step();
    check("late_rvalid_ignored", rv_cyc, -1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!ifu_req && $urandom % 4 == 0) begin
        ifu_req = 1; ifu_addr = {$urandom, $urandom} & ~64'h3;
      end else if (ifu_req && $urandom % 25 == 0) begin
        ifu_req = 0;
      end
      if (!lsu_req && $urandom % 4 == 0) begin
        lsu_req = 1; lsu_addr = {$urandom, $urandom}; lsu_write = $urandom % 2;
        lsu_wdata = {$urandom, $urandom}; lsu_size = 3'($urandom % 4);
      end else if (lsu_req && $urandom % 25 == 0) begin
        lsu_req = 0;
      end
      bus_rdata = {$urandom, $urandom}; bus_ready = 0; bus_rvalid = 0;
      if (m_offer) begin
`ifdef YSYX_050518_MEM_ARB_TIMEOUT_EN
        bus_ready = 1;
`else
        bus_ready = ($urandom % 3 != 0);
`endif
        if (bus_ready) begin
          if ($urandom % 2 == 1) bus_rvalid = 1;
          else rv_left = 1 + $urandom % 3;
        end
      end else if (m_wait) begin
        rv_left--;
        if (rv_left <= 0) bus_rvalid = 1;
      end else begin
        bus_rvalid = ($urandom % 8 == 0);
      end
      step();
      if (g_ifu) ifu_req = 0;
      if (g_lsu) lsu_req = 0;
    end

`ifdef YSYX_050518_MEM_ARB_TIMEOUT_EN
    do_reset();
    lsu_req = 1; lsu_write = 0; lsu_addr = 64'h300; lsu_size = 3'b011;
    step(); lsu_req = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (lsu_rvalid) begin
        seen = 1;
        check("to_bus_err", bus_err, 1);
        check("to_rdata", lsu_rdata, 0);
        check("to_ifu_rvalid", ifu_rvalid, 0);
      end
      @(negedge clk);
    end
    check("to_response_seen", seen, 1);
    #1;
    check("to_err_one_cycle", bus_err, 0);
    @(negedge clk);
`else
    seen = 0;
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
